// File: rtl/debug_disp_pkg.sv
// debug_disp_pkg: mode encodings and seven-segment decode shared by the debug display.
package debug_disp_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_STEP   = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Segment order a..g, a in the MSB, active-low.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronises an active-low key, debounces it and pulses once per press.
module key_debouncer
    import debug_disp_pkg::*;
#(
    parameter int DEBOUNCE = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic level_o,
    output logic press_strobe_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          strobe_q, strobe_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = '0;
        level_d  = level_q;
        strobe_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) begin
                level_d  = ~level_q;
                strobe_d = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= 2'b11;
            level_q  <= 1'b1;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], key_n_i};
            level_q  <= level_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o        = level_q;
    assign press_strobe_o = strobe_q;

endmodule

// File: rtl/debug_probe_display.sv
// debug_probe_display: selects a probe channel (direct/step/scan) and drives hex digits.
module debug_probe_display
    import debug_disp_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int W          = 16,
    parameter int DEBOUNCE   = 250000,
    parameter int SCAN_TICKS = 50000000,
    parameter int SW_W       = $clog2(N_CH),
    parameter int ND         = W / 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_CH*W-1:0] ch_data_i,
    input  logic [SW_W-1:0]   sw_sel_i,
    input  logic [1:0]        mode_i,
    input  logic              key_step_n_i,
    input  logic              hold_i,
    output logic [SW_W-1:0]   ch_idx_o,
    output logic [W-1:0]      digits_o,
    output logic              key_strobe_o,
    output logic [ND*7-1:0]   hex_seg_o
);

    localparam int SCW = $clog2(SCAN_TICKS);

    mode_e          mode;
    logic           key_level, key_strobe, key_press, tc;
    logic [SW_W-1:0] ch_idx_q, ch_idx_d, idx_inc;
    logic [SCW-1:0] scan_q, scan_d;
    logic [W-1:0]   digits_q, digits_d;

    key_debouncer #(.DEBOUNCE(DEBOUNCE)) u_key (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .key_n_i        (key_step_n_i),
        .level_o        (key_level),
        .press_strobe_o (key_strobe)
    );

    assign mode      = mode_e'(mode_i);
    assign key_press = key_strobe & ~key_level;
    assign tc        = scan_q == SCW'(SCAN_TICKS - 1);
    assign idx_inc   = (ch_idx_q == SW_W'(N_CH - 1)) ? '0 : ch_idx_q + 1'b1;

    always_comb begin
        scan_d   = '0;
        ch_idx_d = ch_idx_q;
        if (mode == MODE_SCAN) begin
            scan_d   = tc ? '0 : scan_q + 1'b1;
            ch_idx_d = tc ? idx_inc : ch_idx_q;
        end else if (mode == MODE_STEP) begin
            ch_idx_d = key_press ? idx_inc : ch_idx_q;
        end else if ({1'b0, sw_sel_i} < (SW_W + 1)'(N_CH)) begin
            // Out-of-range switch settings keep the previous channel.
            ch_idx_d = sw_sel_i;
        end
        digits_d = hold_i ? digits_q : ch_data_i[ch_idx_q*W +: W];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ch_idx_q <= '0;
            scan_q   <= '0;
            digits_q <= '0;
        end else begin
            ch_idx_q <= ch_idx_d;
            scan_q   <= scan_d;
            digits_q <= digits_d;
        end
    end

    for (genvar d = 0; d < ND; d++) begin : g_seg
        assign hex_seg_o[d*7 +: 7] = hex_to_seg(digits_q[d*4 +: 4]);
    end

    assign ch_idx_o     = ch_idx_q;
    assign digits_o     = digits_q;
    assign key_strobe_o = key_strobe;

endmodule

// File: tb/tb_debug_probe_display.sv
// tb_debug_probe_display: directed checks of channel select modes, debounce, hold and decode.
module tb_debug_probe_display;

    localparam int N_CH = 8;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH*W-1:0] ch_data;
    logic [2:0]        sw_sel;
    logic [1:0]        mode;
    logic              key_n;
    logic              hold;
    logic [2:0]        ch_idx;
    logic [W-1:0]      digits;
    logic              key_strobe;
    logic [27:0]       hex_seg;

    int n_checks = 0;
    int n_errors = 0;
    int strobes;

    debug_probe_display #(
        .N_CH(N_CH), .W(W), .DEBOUNCE(4), .SCAN_TICKS(5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ch_data_i    (ch_data),
        .sw_sel_i     (sw_sel),
        .mode_i       (mode),
        .key_step_n_i (key_n),
        .hold_i       (hold),
        .ch_idx_o     (ch_idx),
        .digits_o     (digits),
        .key_strobe_o (key_strobe),
        .hex_seg_o    (hex_seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            strobes += int'(key_strobe);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; sw_sel = 3'd0; key_n = 1'b1; hold = 1'b0;
        for (int k = 0; k < N_CH; k++) ch_data[k*W +: W] = 16'(16'h1111 * k);
        tick(2);
        check("rst_idx", 32'(ch_idx), 0);
        check("rst_digits", 32'(digits), 0);
        check("rst_strobe", 32'(key_strobe), 0);
        check("rst_seg", 32'(hex_seg), 32'({4{7'b0000001}}));

        rst = 1'b0; sw_sel = 3'd3;
        tick(1);
        check("dir_idx3", 32'(ch_idx), 3);
        tick(1);
        check("dir_dig3", 32'(digits), 32'h3333);
        check("dir_seg3", 32'(hex_seg), 32'({4{7'b0000110}}));
        sw_sel = 3'd7;
        tick(2);
        check("dir_dig7", 32'(digits), 32'h7777);
        check("dir_seg7", 32'(hex_seg), 32'({4{7'b0001111}}));
        ch_data[7*W +: W] = 16'h4C2F;
        tick(1);
        check("seg_mix", 32'(hex_seg), 32'({7'b1001100, 7'b0110001, 7'b0010010, 7'b0111000}));
        ch_data[7*W +: W] = 16'h7777;

        sw_sel = 3'd6;
        tick(1);
        mode = 2'b01; strobes = 0;
        key_n = 1'b0; tick(10); key_n = 1'b1; tick(10);
        check("step_idx7", 32'(ch_idx), 7);
        key_n = 1'b0; tick(10); key_n = 1'b1; tick(10);
        check("step_strobes", 32'(strobes), 2);
        check("step_idx0", 32'(ch_idx), 0);
        check("step_dig0", 32'(digits), 0);

        strobes = 0;
        repeat (5) begin
            key_n = 1'b0; tick(3); key_n = 1'b1; tick(1);
        end
        tick(4);
        check("glitch_strobes", 32'(strobes), 0);
        check("glitch_idx", 32'(ch_idx), 0);

        mode = 2'b00; sw_sel = 3'd2;
        tick(1);
        mode = 2'b10;
        tick(5);
        check("scan_idx3", 32'(ch_idx), 3);
        tick(5);
        check("scan_idx4", 32'(ch_idx), 4);
        tick(15);
        check("scan_idx7", 32'(ch_idx), 7);
        tick(5);
        check("scan_wrap", 32'(ch_idx), 0);
        tick(3);
        key_n = 1'b0;
        tick(6);
        check("scan_tc_strobe", 32'(key_strobe), 1);
        check("scan_tc_pre", 32'(ch_idx), 1);
        tick(1);
        check("scan_tc_once", 32'(ch_idx), 2);
        key_n = 1'b1;

        mode = 2'b00; sw_sel = 3'd5;
        tick(2);
        check("hold_pre", 32'(digits), 32'h5555);
        hold = 1'b1; sw_sel = 3'd1; ch_data[5*W +: W] = 16'hAAAA;
        tick(2);
        check("hold_dig", 32'(digits), 32'h5555);
        check("hold_idx", 32'(ch_idx), 1);
        hold = 1'b0;
        tick(1);
        check("hold_rel", 32'(digits), 32'h1111);
        ch_data[5*W +: W] = 16'h5555;

        mode = 2'b11; sw_sel = 3'd6;
        tick(1);
        check("rsvd_direct", 32'(ch_idx), 6);

        mode = 2'b00; key_n = 1'b0;
        tick(8);
        sw_sel = 3'd4;
        tick(1);
        mode = 2'b10;
        tick(2);
        check("prerst_idx", 32'(ch_idx), 4);
        rst = 1'b1;
        tick(1);
        check("mid_rst_idx", 32'(ch_idx), 0);
        check("mid_rst_dig", 32'(digits), 0);
        check("mid_rst_strobe", 32'(key_strobe), 0);
        rst = 1'b0; mode = 2'b01; strobes = 0;
        tick(5);
        check("redeb_wait", 32'(strobes), 0);
        tick(5);
        check("redeb_strobe", 32'(strobes), 1);
        check("redeb_idx", 32'(ch_idx), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
